// File: rtl/tick_rate_controller.sv
// tick_rate_controller
//   Run/pause/idle controlled tick generator with a selectable divider
//   (fast or slow), a debounced rate select and a two-digit BCD tick count.
//
// Ports
//   clk        sole clock, all state changes on posedge
//   reset      synchronous active-high reset, overrides everything
//   start      run request (IDLE->RUN, PAUSE->RUN)
//   stop       pause request (RUN->PAUSE), wins over start
//   clear      return to IDLE and zero count/divider, wins over all
//   fast_sel   raw rate select, 1 = fast, 0 = slow
//   tick       registered one-cycle pulse per divider period
//   wrap       registered one-cycle pulse on the 99->00 rollover
//   rate_fast  rate currently applied to the divider
//   state      IDLE=00, RUN=01, PAUSE=10
//   ones/tens  BCD digits of the tick count
module tick_rate_controller #(
   parameter int unsigned DIV_FAST = 5,
   parameter int unsigned DIV_SLOW = 1_000_000,
   parameter int unsigned DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       clear,
   input  logic       fast_sel,
   output logic       tick,
   output logic       wrap,
   output logic       rate_fast,
   output logic [1:0] state,
   output logic [3:0] ones,
   output logic [3:0] tens
);

   localparam logic [1:0] StIdle  = 2'b00;
   localparam logic [1:0] StRun   = 2'b01;
   localparam logic [1:0] StPause = 2'b10;

   localparam int unsigned DbW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);
   localparam logic [23:0] FastLast = 24'(DIV_FAST - 1);
   localparam logic [23:0] SlowLast = 24'(DIV_SLOW - 1);

   logic [1:0]     state_q, state_d;
   logic [23:0]    div_cnt_q, div_cnt_d;
   logic           tick_q, tick_d;
   logic           wrap_q, wrap_d;
   logic           rate_fast_q, rate_fast_d;
   logic           sel_db_q, sel_db_d;
   logic [DbW-1:0] db_cnt_q, db_cnt_d;
   logic [3:0]     ones_q, ones_d;
   logic [3:0]     tens_q, tens_d;

   logic [23:0]    div_last;
   logic           advance;
   logic           rollover;
   logic           idle_like;

   always_comb begin
      // Debounce: sel_db follows fast_sel only after DEBOUNCE consecutive
      // disagreeing edges; any agreeing cycle restarts the count.
      sel_db_d = sel_db_q;
      db_cnt_d = db_cnt_q;
      if (fast_sel == sel_db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DbLast) begin
         sel_db_d = fast_sel;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 1'b1;
      end

      div_last  = rate_fast_q ? FastLast : SlowLast;
      // The divider only advances on edges where the FSM stays in RUN, so an
      // edge that pauses freezes div_cnt at the value seen when stop was raised.
      advance   = (state_q == StRun) && !stop && !clear;
      rollover  = advance && (div_cnt_q == div_last);
      idle_like = (state_q != StRun) && (state_q != StPause);

      state_d = state_q;
      if (clear) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle:  if (start && !stop) state_d = StRun;
            StRun:   if (stop) state_d = StPause;
            StPause: if (!stop && start) state_d = StRun;
            default: state_d = StIdle;
         endcase
      end

      div_cnt_d = div_cnt_q;
      if (clear || idle_like) begin
         div_cnt_d = '0;
      end else if (advance) begin
         div_cnt_d = rollover ? 24'd0 : div_cnt_q + 24'd1;
      end

      tick_d = rollover;
      wrap_d = rollover && (ones_q == 4'd9) && (tens_q == 4'd9);

      ones_d = ones_q;
      tens_d = tens_q;
      if (clear || idle_like) begin
         ones_d = 4'd0;
         tens_d = 4'd0;
      end else if (rollover) begin
         if (ones_q == 4'd9) begin
            ones_d = 4'd0;
            tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
         end else begin
            ones_d = ones_q + 4'd1;
         end
      end

      // Rate changes only between periods while running; in IDLE it tracks the
      // filtered select immediately, in PAUSE it holds.
      rate_fast_d = rate_fast_q;
      if (clear || idle_like || rollover) begin
         rate_fast_d = sel_db_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         div_cnt_q   <= '0;
         tick_q      <= 1'b0;
         wrap_q      <= 1'b0;
         rate_fast_q <= 1'b0;
         sel_db_q    <= 1'b0;
         db_cnt_q    <= '0;
         ones_q      <= 4'd0;
         tens_q      <= 4'd0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         tick_q      <= tick_d;
         wrap_q      <= wrap_d;
         rate_fast_q <= rate_fast_d;
         sel_db_q    <= sel_db_d;
         db_cnt_q    <= db_cnt_d;
         ones_q      <= ones_d;
         tens_q      <= tens_d;
      end
   end

   assign tick      = tick_q;
   assign wrap      = wrap_q;
   assign rate_fast = rate_fast_q;
   assign state     = state_q;
   assign ones      = ones_q;
   assign tens      = tens_q;

endmodule

// File: doc/tick_rate_controller.md
TICK_RATE_CONTROLLER -- requirements
Module: tick_rate_controller

Interface
REQ-001 SHALL have parameter DIV_FAST, default 5, meaning fast tick period in clk cycles (legal range 1 to 2^24-1).
REQ-002 SHALL have parameter DIV_SLOW, default 1_000_000, meaning slow tick period in clk cycles (legal range 1 to 2^24-1).
REQ-003 SHALL have parameter DEBOUNCE, default 4, meaning the number of consecutive stable cycles fast_sel must hold before it is accepted (minimum 1).
REQ-004 clk  input  1  sole clock; all state changes on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  run request, sampled each cycle.
REQ-007 stop  input  1  pause request, sampled each cycle.
REQ-008 clear  input  1  return to idle and zero the count.
REQ-009 fast_sel  input  1  raw rate select (1 = fast, 0 = slow); synchronous to clk.
REQ-010 tick  output  1  registered one-cycle pulse, one per tick period.
REQ-011 wrap  output  1  registered one-cycle pulse on the 99->00 count rollover.
REQ-012 rate_fast  output  1  rate currently applied to the divider.
REQ-013 state  output  2  IDLE=00, RUN=01, PAUSE=10; 11 unused.
REQ-014 ones  output  4  BCD units digit.
REQ-015 tens  output  4  BCD tens digit.

Function
REQ-016 FSM transitions SHALL be: IDLE->RUN on start; RUN->PAUSE on stop; PAUSE->RUN on start; any state->IDLE on clear.
REQ-017 Input priority SHALL be clear > stop > start; start and stop asserted together in RUN or PAUSE SHALL yield PAUSE.
REQ-018 start and stop asserted together in IDLE SHALL leave the FSM in IDLE.
REQ-019 Divider SHALL be a 24-bit div_cnt; D is DIV_FAST when rate_fast=1, else DIV_SLOW.
REQ-020 In RUN, each edge: if div_cnt==D-1 then div_cnt<=0 and tick<=1, else div_cnt<=div_cnt+1 and tick<=0.
REQ-021 Outside RUN, tick SHALL be 0.
REQ-022 In PAUSE, div_cnt SHALL hold its value; in IDLE, div_cnt SHALL be 0.
REQ-023 The first tick SHALL occur D cycles after the first cycle state==RUN, counted from div_cnt=0; ticks SHALL then repeat every D cycles.
REQ-024 With D=1, tick SHALL remain high continuously while in RUN.
REQ-025 A resume from PAUSE SHALL continue from the held div_cnt, so the remaining partial period is preserved.
REQ-026 Debounce: a filtered select sel_db SHALL take the fast_sel value at the DEBOUNCE-th consecutive edge on which fast_sel != sel_db.
REQ-027 Any cycle with fast_sel == sel_db SHALL reset the debounce count.
REQ-028 In IDLE, rate_fast SHALL load sel_db every cycle.
REQ-029 In RUN, rate_fast SHALL load sel_db only on the edge where div_cnt rolls over (D-1 -> 0), so the period in progress is never truncated or extended.
REQ-030 In PAUSE, rate_fast SHALL hold; a pending change SHALL apply at the first rollover after resume.
REQ-031 BCD count: on each edge that sets tick<=1, ones SHALL increment.
REQ-032 ones 9->0 SHALL increment tens.
REQ-033 tens=9 and ones=9 SHALL wrap to 00 and set wrap<=1 on the same edge as tick; otherwise wrap<=0.
REQ-034 Digits SHALL hold in PAUSE.
REQ-035 clear SHALL zero ones, tens, div_cnt, tick and wrap on the next edge.
REQ-036 Digits SHALL never leave the range 0-9.

Reset
REQ-037 reset SHALL, on the next edge, set state=IDLE, tick=0, wrap=0, ones=0, tens=0, rate_fast=0, sel_db=0, div_cnt=0 and debounce count=0.
REQ-038 reset SHALL override all other inputs, including mid-operation in RUN or PAUSE.

Verification (bench params DIV_FAST=5, DIV_SLOW=20, DEBOUNCE=4)
REQ-039 fast_sel=1 held from reset release, start pulsed at cycle 10 -> rate_fast=1 at the 4th edge after reset; ticks every 5 cycles, first tick 5 cycles after state==RUN.
REQ-040 Run 100 fast ticks -> ones/tens step 00..99; the 100th tick returns 00 with wrap=1 in that same cycle; wrap=0 elsewhere.
REQ-041 stop asserted when div_cnt=2, held in PAUSE 10 cycles, then start -> no tick during PAUSE, digits frozen; next tick 3 cycles after RUN resumes.
REQ-042 In RUN slow: fast_sel glitch of 3 cycles -> rate_fast unchanged; fast_sel held 4 cycles -> rate_fast=1 only at the next rollover, and that slow period is exactly 20 cycles.
REQ-043 start+stop together in RUN -> PAUSE; clear+start together in PAUSE -> IDLE with ones=tens=0.
REQ-044 reset asserted mid-RUN with digits 37 -> next cycle state=00, ones=tens=0, tick=0, rate_fast=0.
